// File: rtl/ips_pkg.sv
// Shared encodings for the phototransistor frequency classifier.
package ips_pkg;

    // Class reported per channel.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'b00,
        CLS_FRIEND = 2'b01,
        CLS_FOE    = 2'b10
    } cls_t;

    // Per-channel tracking state.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } chan_state_t;

endpackage

// File: rtl/ips_chan.sv
// One phototransistor channel: synchronizer, rising-edge detect, saturating
// edge counter, window classifier and consecutive-window confirm filter.
module ips_chan
    import ips_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FRIEND_LO = 11,
    parameter int FRIEND_HI = 39,
    parameter int FOE_LO    = 41,
    parameter int FOE_HI    = 109,
    parameter int CONFIRM   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             photo,
    input  logic             win_end,
    output logic [CNT_W-1:0] count,
    output cls_t             cls
);

    localparam int CONF_W = (CONFIRM > 1) ? $clog2(CONFIRM + 1) : 1;
    localparam logic [CONF_W-1:0] CONF_TGT = CONF_W'(CONFIRM);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [31:0] F_LO = 32'(FRIEND_LO);
    localparam logic [31:0] F_HI = 32'(FRIEND_HI);
    localparam logic [31:0] X_LO = 32'(FOE_LO);
    localparam logic [31:0] X_HI = 32'(FOE_HI);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    cls_t              cls_q, cls_d;
    cls_t              raw_prev_q, raw_prev_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    chan_state_t       state_q, state_d;

    logic              edge_det;
    cls_t              raw_cls;
    logic [CONF_W-1:0] conf_inc;

    // Saturated counts are treated as out of band even if they land in a range.
    function automatic cls_t classify(input logic [CNT_W-1:0] c);
        logic [31:0] v;
        v = 32'(c);
        if (c == CNT_MAX)
            return CLS_NONE;
        else if (v >= F_LO && v <= F_HI)
            return CLS_FRIEND;
        else if (v >= X_LO && v <= X_HI)
            return CLS_FOE;
        else
            return CLS_NONE;
    endfunction

    assign edge_det = sync2_q & ~hist_q;
    assign raw_cls  = classify(cnt_q);
    assign conf_inc = (conf_q >= CONF_TGT) ? conf_q : conf_q + CONF_W'(1);
    assign count    = count_q;
    assign cls      = cls_q;

    // Next-state: synchronizer shift, edge counting, window-end load and confirm.
    always_comb begin
        sync1_d    = photo;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        cls_d      = cls_q;
        raw_prev_d = raw_prev_q;
        conf_d     = conf_q;
        state_d    = state_q;
        if (win_end) begin
            // An edge landing on the wrap cycle belongs to the new window.
            cnt_d      = CNT_W'(edge_det);
            count_d    = cnt_q;
            raw_prev_d = raw_cls;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                    conf_d  = CONF_W'(1);
                end
                default: begin
                    conf_d = (raw_cls == raw_prev_q) ? conf_inc : CONF_W'(1);
                end
            endcase
            if (conf_d == CONF_TGT)
                cls_d = raw_cls;
        end else if (edge_det && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            cnt_q      <= '0;
            count_q    <= '0;
            cls_q      <= CLS_NONE;
            raw_prev_q <= CLS_NONE;
            conf_q     <= '0;
            state_q    <= ST_IDLE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            cls_q      <= cls_d;
            raw_prev_q <= raw_prev_d;
            conf_q     <= conf_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: rtl/ips_freq_classifier.sv
// Multi-channel pulse-rate classifier: shared gate-window timer, one
// ips_chan per phototransistor, and a lowest-index FOE target encoder.
module ips_freq_classifier
    import ips_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 16,
    parameter int WINDOW_CYC = 10000000,
    parameter int FRIEND_LO  = 11,
    parameter int FRIEND_HI  = 39,
    parameter int FOE_LO     = 41,
    parameter int FOE_HI     = 109,
    parameter int CONFIRM    = 2,
    localparam int TCH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       photo,
    output logic [2*NUM_CH-1:0]     cls,
    output logic [CNT_W*NUM_CH-1:0] count,
    output logic                    win_done,
    output logic                    target_valid,
    output logic [TCH_W-1:0]        target_ch
);

    localparam int TMR_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYC - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             win_done_q, win_done_d;
    logic             target_valid_q, target_valid_d;
    logic [TCH_W-1:0] target_ch_q, target_ch_d;
    logic             win_end;
    cls_t             cls_ch [NUM_CH];

    assign win_end      = (timer_q == TMR_LAST);
    assign win_done     = win_done_q;
    assign target_valid = target_valid_q;
    assign target_ch    = target_ch_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            ips_chan #(
                .CNT_W    (CNT_W),
                .FRIEND_LO(FRIEND_LO),
                .FRIEND_HI(FRIEND_HI),
                .FOE_LO   (FOE_LO),
                .FOE_HI   (FOE_HI),
                .CONFIRM  (CONFIRM)
            ) u_chan (
                .clock  (clock),
                .reset  (reset),
                .photo  (photo[gi]),
                .win_end(win_end),
                .count  (count[gi*CNT_W +: CNT_W]),
                .cls    (cls_ch[gi])
            );
            assign cls[2*gi +: 2] = cls_ch[gi];
        end
    endgenerate

    // Window timer wraps on the last cycle; the strobe follows the count load.
    always_comb begin
        timer_d    = win_end ? '0 : timer_q + TMR_W'(1);
        win_done_d = win_end;
    end

    // Lowest-index channel whose confirmed class is FOE wins.
    always_comb begin
        target_valid_d = 1'b0;
        target_ch_d    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cls_ch[i] == CLS_FOE) begin
                target_valid_d = 1'b1;
                target_ch_d    = TCH_W'(i);
            end
        end
    end

    // Top-level registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q        <= '0;
            win_done_q     <= 1'b0;
            target_valid_q <= 1'b0;
            target_ch_q    <= '0;
        end else begin
            timer_q        <= timer_d;
            win_done_q     <= win_done_d;
            target_valid_q <= target_valid_d;
            target_ch_q    <= target_ch_d;
        end
    end

endmodule

// File: tb/tb_ips_freq_classifier.sv
// Bench for ips_freq_classifier: directed window table, reset corner case,
// then randomized windows against a history-based reference model.
module tb_ips_freq_classifier;

    localparam int NCH  = 3;
    localparam int WIN  = 1000;
    localparam int CONF = 2;
    localparam int CW   = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    photo = '0;
    logic [NCH-1:0]    photo_sat = '0;
    logic [2*NCH-1:0]  cls, cls_sat;
    logic [CW*NCH-1:0] count;
    logic [4*NCH-1:0]  count_sat;
    logic              win_done, win_done_sat;
    logic              target_valid, target_valid_sat;
    logic [1:0]        target_ch, target_ch_sat;

    ips_freq_classifier #(
        .NUM_CH(NCH), .CNT_W(CW), .WINDOW_CYC(WIN), .CONFIRM(CONF)
    ) dut (
        .clock(clock), .reset(reset), .photo(photo), .cls(cls), .count(count),
        .win_done(win_done), .target_valid(target_valid), .target_ch(target_ch)
    );

    ips_freq_classifier #(
        .NUM_CH(NCH), .CNT_W(4), .WINDOW_CYC(WIN), .CONFIRM(CONF)
    ) dut_sat (
        .clock(clock), .reset(reset), .photo(photo_sat), .cls(cls_sat), .count(count_sat),
        .win_done(win_done_sat), .target_valid(target_valid_sat), .target_ch(target_ch_sat)
    );

    always #5 clock = ~clock;

    // Saturation instance: channel 0 toggles every cycle for the whole run.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            photo_sat[0] = ~photo_sat[0];
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         n[3];
        logic [2:0] late;
        int         cnt[3];
        int         cl[3];
        int         tv;
        int         tch;
    } vec_t;

    vec_t vecs[11];

    task automatic set_vec(input int i, input int n0, input int n1, input int n2,
                           input logic [2:0] late, input int c0, input int c1, input int c2,
                           input int k0, input int k1, input int k2, input int tv, input int tch);
        vecs[i].n[0] = n0;   vecs[i].n[1] = n1;   vecs[i].n[2] = n2;
        vecs[i].late = late;
        vecs[i].cnt[0] = c0; vecs[i].cnt[1] = c1; vecs[i].cnt[2] = c2;
        vecs[i].cl[0] = k0;  vecs[i].cl[1] = k1;  vecs[i].cl[2] = k2;
        vecs[i].tv = tv;     vecs[i].tch = tch;
    endtask

    // Current window stimulus and expectations.
    int         cur_n[3];
    logic [2:0] cur_late;
    int         exp_cnt[3];
    int         exp_cls[3];
    int         exp_tv, exp_tch;
    int         pend_tv = 0, pend_tch = 0;
    int         win_idx = 0;

    // Reference model: per-channel history of raw classes.
    int hist[3][$];
    int mcls[3];
    int carry[3];

    function automatic int raw_of(input int c);
        if (c == (2**CW) - 1) return 0;
        if (c >= 11 && c <= 39) return 1;
        if (c >= 41 && c <= 109) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch].delete();
            mcls[ch]  = 0;
            carry[ch] = 0;
        end
    endtask

    task automatic model_window();
        for (int ch = 0; ch < NCH; ch++) begin
            int c;
            int r;
            bit same;
            c = cur_n[ch] + carry[ch];
            if (c > (2**CW) - 1) c = (2**CW) - 1;
            carry[ch] = int'(cur_late[ch]);
            r = raw_of(c);
            hist[ch].push_back(r);
            if (hist[ch].size() >= CONF) begin
                same = 1'b1;
                for (int k = 0; k < CONF; k++)
                    if (hist[ch][hist[ch].size() - 1 - k] != r) same = 1'b0;
                if (same) mcls[ch] = r;
            end
            exp_cnt[ch] = c;
            exp_cls[ch] = mcls[ch];
        end
        exp_tv  = 0;
        exp_tch = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mcls[ch] == 2 && exp_tv == 0) begin
                exp_tv  = 1;
                exp_tch = ch;
            end
        end
    endtask

    function automatic bit pulse_at(input int c, input int n);
        return (c >= 10) && (((c - 10) % 8) < 4) && (((c - 10) / 8) < n);
    endfunction

    // One full gate window; assumes the first posedge is cycle 1 of the window.
    task automatic run_window();
        for (int c = 1; c <= WIN; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) begin
                check("target_valid", int'(target_valid), pend_tv);
                check("target_ch", int'(target_ch), pend_tch);
                check("win_done_one_cycle", int'(win_done), 0);
            end
            if (c == WIN - 1)
                check("win_done_early", int'(win_done), 0);
            if (c == WIN) begin
                check("win_done", int'(win_done), 1);
                for (int ch = 0; ch < NCH; ch++) begin
                    check($sformatf("count%0d", ch), int'(count[ch*CW +: CW]), exp_cnt[ch]);
                    check($sformatf("cls%0d", ch), int'(cls[2*ch +: 2]), exp_cls[ch]);
                end
                check("sat_count", int'(count_sat[3:0]), 15);
                check("sat_cls", int'(cls_sat[1:0]), 0);
                $display("window %0d: edges=%0d/%0d/%0d late=%b count=%0d/%0d/%0d cls=%b",
                         win_idx, cur_n[0], cur_n[1], cur_n[2], cur_late,
                         count[0 +: CW], count[CW +: CW], count[2*CW +: CW], cls);
                win_idx++;
                pend_tv  = exp_tv;
                pend_tch = exp_tch;
            end
            for (int ch = 0; ch < NCH; ch++)
                photo[ch] = pulse_at(c, cur_n[ch]) || (cur_late[ch] && c >= 997 && c <= 999);
        end
    endtask

    initial begin
        bit found;
        int bnd[7] = '{10, 11, 39, 40, 41, 109, 110};

        //        idx  edges          late    count         cls      tv tch
        set_vec(0,  25, 60, 60,  3'b000, 25, 60, 60,   0, 0, 0, 0, 0);
        set_vec(1,  25, 60, 60,  3'b000, 25, 60, 60,   1, 2, 2, 1, 1);
        set_vec(2,  40, 11, 109, 3'b001, 40, 11, 109,  1, 2, 2, 1, 1);
        set_vec(3,  39, 11, 110, 3'b000, 40, 11, 110,  0, 1, 2, 1, 2);
        set_vec(4,  0,  0,  110, 3'b000, 0,  0,  110,  0, 1, 0, 0, 0);
        set_vec(5,  25, 41, 0,   3'b000, 25, 41, 0,    0, 1, 0, 0, 0);
        set_vec(6,  60, 41, 39,  3'b000, 60, 41, 39,   0, 2, 0, 1, 1);
        set_vec(7,  25, 0,  39,  3'b000, 25, 0,  39,   0, 2, 1, 1, 1);
        set_vec(8,  60, 0,  39,  3'b000, 60, 0,  39,   0, 0, 1, 0, 0);
        set_vec(9,  50, 50, 50,  3'b000, 50, 50, 50,   2, 0, 1, 1, 0);
        set_vec(10, 50, 50, 50,  3'b000, 50, 50, 50,   2, 2, 2, 1, 0);

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("rst_win_done", int'(win_done), 0);
        check("rst_count", int'(count != 0), 0);
        check("rst_cls", int'(cls), 0);
        check("rst_target_valid", int'(target_valid), 0);
        check("rst_target_ch", int'(target_ch), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed windows.
        for (int v = 0; v < 11; v++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                cur_n[ch]   = vecs[v].n[ch];
                exp_cnt[ch] = vecs[v].cnt[ch];
                exp_cls[ch] = vecs[v].cl[ch];
            end
            cur_late = vecs[v].late;
            exp_tv   = vecs[v].tv;
            exp_tch  = vecs[v].tch;
            run_window();
        end

        // Mid-window reset with ch0 held high through release.
        for (int c = 1; c <= 500; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) begin
                check("target_valid", int'(target_valid), pend_tv);
                check("target_ch", int'(target_ch), pend_tch);
            end
            photo[1] = pulse_at(c, 30);
            photo[0] = (c >= 400);
        end
        reset    = 1'b1;
        photo[1] = 1'b0;
        #1;
        check("mid_rst_win_done", int'(win_done), 0);
        check("mid_rst_count", int'(count != 0), 0);
        check("mid_rst_cls", int'(cls), 0);
        check("mid_rst_target_valid", int'(target_valid), 0);
        check("mid_rst_target_ch", int'(target_ch), 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clock);
            #1;
            if (c == 1)
                check("post_rst_target_valid", int'(target_valid), 0);
            if (win_done) begin
                check("post_rst_period", c, WIN);
                check("post_rst_count0", int'(count[0 +: CW]), 1);
                check("post_rst_count1", int'(count[CW +: CW]), 0);
                check("post_rst_count2", int'(count[2*CW +: CW]), 0);
                check("post_rst_cls", int'(cls), 0);
                $display("window %0d: post-reset count=%0d/%0d/%0d after %0d cycles",
                         win_idx, count[0 +: CW], count[CW +: CW], count[2*CW +: CW], c);
                win_idx++;
                found = 1'b1;
                photo = '0;
                break;
            end
        end
        if (!found)
            check("post_rst_win_done_seen", 0, 1);

        model_reset();
        cur_n[0] = 1; cur_n[1] = 0; cur_n[2] = 0;
        cur_late = '0;
        model_window();
        pend_tv  = exp_tv;
        pend_tch = exp_tch;
        for (int ch = 0; ch < NCH; ch++) cur_n[ch] = 0;

        // Randomized windows against the reference model.
        for (int w = 0; w < 10; w++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                int r;
                r = int'($urandom_range(0, 3));
                if (r == 1)
                    cur_n[ch] = bnd[$urandom_range(0, 6)];
                else if (r >= 2)
                    cur_n[ch] = int'($urandom_range(0, 110));
                cur_late[ch] = ($urandom_range(0, 5) == 0);
            end
            model_window();
            run_window();
        end

        @(posedge clock);
        #1;
        check("final_target_valid", int'(target_valid), pend_tv);
        check("final_target_ch", int'(target_ch), pend_tch);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ips_freq_classifier.md
IPS_FREQ_CLASSIFIER -- requirements
Module: ips_freq_classifier

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning the number of phototransistor channels.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the edge-counter width.
REQ-003 The block SHALL have parameter WINDOW_CYC, default 10000000, meaning the gate window length in clock cycles.
REQ-004 The block SHALL have parameters FRIEND_LO / FRIEND_HI, defaults 11 / 39, meaning the inclusive friend rising-edge-count range.
REQ-005 The block SHALL have parameters FOE_LO / FOE_HI, defaults 41 / 109, meaning the inclusive foe rising-edge-count range.
REQ-006 The block SHALL have parameter CONFIRM, default 2, meaning the consecutive matching windows needed before a class output changes.
REQ-007 The block SHALL have port clock, input, 1 bit, the single clock.
REQ-008 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 The block SHALL have port photo, input, NUM_CH bits, raw asynchronous phototransistor inputs.
REQ-010 The block SHALL have port cls, output, 2*NUM_CH bits, the confirmed class per channel (channel i at bits 2i+1:2i).
REQ-011 The block SHALL have port count, output, CNT_W*NUM_CH bits, the last completed window's edge count per channel.
REQ-012 The block SHALL have port win_done, output, 1 bit, a one-cycle strobe when count is updated.
REQ-013 The block SHALL have port target_valid, output, 1 bit, high when any channel's confirmed class is FOE.
REQ-014 The block SHALL have port target_ch, output, $clog2(NUM_CH) bits, the lowest-index channel currently FOE, 0 when none.

Function
REQ-015 Each photo bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector; edge latency is 3 cycles from input change.
REQ-016 All channels SHALL count simultaneously and independently, with no priority between channels.
REQ-017 Each channel counter SHALL increment by 1 per rising edge and saturate at 2^CNT_W-1.
REQ-018 A window timer SHALL count 0..WINDOW_CYC-1 and wrap; the wrap cycle is the window end.
REQ-019 At window end, count SHALL load every channel's counter value, win_done SHALL pulse for exactly that cycle, and counters SHALL restart.
REQ-020 An edge on the window-end cycle SHALL be counted in the new window, so the counter loads 1 instead of 0.
REQ-021 The raw class SHALL be FRIEND (2'b01) if the count is in [FRIEND_LO,FRIEND_HI], FOE (2'b10) if in [FOE_LO,FOE_HI], and NONE (2'b00) otherwise (including 40 and a saturated count).
REQ-022 Per channel, a confirm counter SHALL track how many consecutive windows have produced the same raw class; it resets to 1 when the raw class differs from the previous window's raw class.
REQ-023 cls[i] SHALL update to the raw class in the cycle after the window end in which the confirm counter reaches CONFIRM; otherwise cls[i] holds; CONFIRM=1 gives direct update.
REQ-024 target_valid and target_ch SHALL be registered from cls, lagging it by one cycle.
REQ-025 Per-channel state SHALL be: IDLE (after reset, cls=NONE) and TRACK (confirm counting); IDLE moves to TRACK at the first window end; there is no other exit except reset.

Reset
REQ-026 Asserting reset SHALL asynchronously clear synchronizers, edge history, counters, window timer, confirm counters, count, cls, win_done, target_valid and target_ch to 0 / NONE.
REQ-027 Reset mid-window SHALL discard the partial window; the first window after release is a full WINDOW_CYC cycles.
REQ-028 Edge history SHALL reset to 0, so a photo input held high through reset release produces one edge 3 cycles after release.

Structure
REQ-029 A shared package ips_pkg SHALL hold the class encodings CLS_NONE, CLS_FRIEND and CLS_FOE, and the class typedef.
REQ-030 A sub-module ips_chan SHALL implement one channel's synchronizer, edge detect, counter, classifier and confirm logic, generated NUM_CH times; the window timer and target encoder SHALL be in the top level.

Verification (bench: WINDOW_CYC=1000, CONFIRM=2, NUM_CH=3)
REQ-031 25 edges per window on ch0 for 2 windows -> count ch0=25 each window; cls ch0=01 after the 2nd window end; target_valid=0.
REQ-032 60 edges/window on ch1 and 60 on ch2 -> both cls=10 after 2 windows; target_valid=1; target_ch=1.
REQ-033 Alternating windows of 25 and 60 edges on ch0 -> cls ch0 stays 00 indefinitely.
REQ-034 Exactly 40, 11, 109 and 110 edges -> raw class NONE, FRIEND, FOE and NONE respectively; continuous 1-cycle toggling with CNT_W=4 -> count saturates at 15.
REQ-035 Edge on the window-end cycle -> that window excludes it, the next counts it; reset pulse at cycle 500 -> all outputs 0, and the next win_done occurs 1000 cycles after release.
REQ-036 Simultaneous edges on all 3 channels every 20 cycles -> all counts=50 and identical; no channel is dropped.
